rv32i_alu_arbiter: RTL and testbench

Shares the single registered execute-stage ALU between two requesters: port 0 is the main execute path and port 1 is an auxiliary unit, such as an address or CSR calculator.
- Arbitrates one operation per cycle, round-robin or fixed priority.
- Decodes a 4-bit op code into the ALU's one-hot op lines.
- Routes the ALU's 1-cycle-registered result back to the requester that issued it.
- Sits between the decode/issue logic and the ALU inside the execute stage.

---
 rtl/rv32i_alu_pkg.sv | 51 +++++
 rtl/rv32i_alu_arbiter.sv | 105 ++++++++++
 tb/tb_rv32i_alu_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_alu_pkg.sv
// Shared definitions for users of the execute-stage ALU: op code map,
// one-hot decode and the response tag carried alongside an in-flight op.
package rv32i_alu_pkg;

    localparam int ALU_OP_W     = 4;
    localparam int ALU_ONEHOT_W = 14;

    localparam logic [ALU_OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] OP_SLT  = 4'd2;
    localparam logic [ALU_OP_W-1:0] OP_SLTU = 4'd3;
    localparam logic [ALU_OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [ALU_OP_W-1:0] OP_OR   = 4'd5;
    localparam logic [ALU_OP_W-1:0] OP_AND  = 4'd6;
    localparam logic [ALU_OP_W-1:0] OP_SLL  = 4'd7;
    localparam logic [ALU_OP_W-1:0] OP_SRL  = 4'd8;
    localparam logic [ALU_OP_W-1:0] OP_SRA  = 4'd9;
    localparam logic [ALU_OP_W-1:0] OP_EQ   = 4'd10;
    localparam logic [ALU_OP_W-1:0] OP_NEQ  = 4'd11;
    localparam logic [ALU_OP_W-1:0] OP_GE   = 4'd12;
    localparam logic [ALU_OP_W-1:0] OP_GEU  = 4'd13;

    typedef struct packed {
        logic                    illegal;
        logic [ALU_ONEHOT_W-1:0] onehot;
    } op_dec_t;

    typedef struct packed {
        logic busy;
        logic id;
        logic err;
    } tag_t;

    localparam tag_t TAG_IDLE = '{busy: 1'b0, id: 1'b0, err: 1'b0};

    // Illegal codes decode to all-zero op lines so the ALU produces 0.
    function automatic op_dec_t op_decode(input logic [ALU_OP_W-1:0] op);
        op_dec_t d;
        d.illegal = 1'b0;
        d.onehot  = {ALU_ONEHOT_W{1'b0}};
        case (op)
            OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_XOR, OP_OR, OP_AND,
            OP_SLL, OP_SRL, OP_SRA, OP_EQ, OP_NEQ, OP_GE, OP_GEU:
                d.onehot = 14'd1 << op;
            default:
                d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rv32i_alu_arbiter.sv
// Two-requester front end for the shared registered execute-stage ALU:
// grants one op per cycle and steers the 1-cycle result back to its issuer.
module rv32i_alu_arbiter
    import rv32i_alu_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0,
    parameter int XLEN       = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hold,
    input  logic                    flush,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [ALU_OP_W-1:0]     req0_op,
    input  logic [XLEN-1:0]         req0_a,
    input  logic [XLEN-1:0]         req0_b,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [ALU_OP_W-1:0]     req1_op,
    input  logic [XLEN-1:0]         req1_a,
    input  logic [XLEN-1:0]         req1_b,
    output logic                    rsp0_valid,
    output logic                    rsp1_valid,
    output logic                    rsp_err,
    output logic [XLEN-1:0]         rsp_y,
    output logic [XLEN-1:0]         alu_a,
    output logic [XLEN-1:0]         alu_b,
    output logic [ALU_ONEHOT_W-1:0] alu_op,
    input  logic [XLEN-1:0]         alu_y
);

    logic                gnt0_s;
    logic                gnt1_s;
    logic                any_gnt_s;
    logic [ALU_OP_W-1:0] sel_op_s;
    op_dec_t             dec_s;
    tag_t                tag_r;
    logic                last_grant_r;

    // Grant selection; round-robin favours the requester not granted last.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (rst || hold || flush) begin
            gnt0_s = 1'b0;
        end else if (req0_valid && req1_valid) begin
            if (FIXED_PRIO || last_grant_r) begin
                gnt0_s = 1'b1;
            end else begin
                gnt1_s = 1'b1;
            end
        end else if (req0_valid) begin
            gnt0_s = 1'b1;
        end else if (req1_valid) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
        end
    end

    assign any_gnt_s  = gnt0_s | gnt1_s;
    assign req0_ready = gnt0_s;
    assign req1_ready = gnt1_s;

    // Operand steering; idle cycles keep requester 0's operands to limit toggling.
    always_comb begin
        if (gnt1_s) begin
            sel_op_s = req1_op;
            alu_a    = req1_a;
            alu_b    = req1_b;
        end else begin
            sel_op_s = req0_op;
            alu_a    = req0_a;
            alu_b    = req0_b;
        end
        dec_s = op_decode(sel_op_s);
        if (any_gnt_s) begin
            alu_op = dec_s.onehot;
        end else begin
            alu_op = {ALU_ONEHOT_W{1'b0}};
        end
    end

    // In-flight tag and round-robin history; flush wins over any load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_r        <= TAG_IDLE;
            last_grant_r <= 1'b1;
        end else if (flush) begin
            tag_r.busy   <= 1'b0;
        end else if (any_gnt_s) begin
            tag_r        <= '{busy: 1'b1, id: gnt1_s, err: dec_s.illegal};
            last_grant_r <= gnt1_s;
        end else begin
            tag_r.busy   <= 1'b0;
        end
    end

    assign rsp0_valid = tag_r.busy & ~tag_r.id;
    assign rsp1_valid = tag_r.busy &  tag_r.id;
    assign rsp_err    = tag_r.busy &  tag_r.err;
    assign rsp_y      = tag_r.busy ? alu_y : {XLEN{1'b0}};

endmodule

// File: tb/tb_rv32i_alu_arbiter.sv
// Bench for rv32i_alu_arbiter: round-robin and fixed-priority instances share
// one stimulus stream and are compared against a per-instance reference model.
module tb_rv32i_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst, hold, flush;
    logic        v0, v1;
    logic [3:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;

    logic [1:0]  rdy0, rdy1, rv0, rv1, rerr;
    logic [31:0] ry [2];
    logic [31:0] aa [2];
    logic [31:0] ab [2];
    logic [31:0] ay [2];
    logic [13:0] aop [2];

    int n_vec = 0;
    int n_err = 0;

    int          m_last [2];
    bit          m_busy [2];
    int          m_id   [2];
    bit          m_err  [2];
    logic [31:0] m_y    [2];

    always #5 clk = ~clk;

    rv32i_alu_arbiter #(.FIXED_PRIO(1'b0), .XLEN(32)) u_rr (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .req0_valid(v0), .req0_ready(rdy0[0]), .req0_op(op0), .req0_a(a0), .req0_b(b0),
        .req1_valid(v1), .req1_ready(rdy1[0]), .req1_op(op1), .req1_a(a1), .req1_b(b1),
        .rsp0_valid(rv0[0]), .rsp1_valid(rv1[0]), .rsp_err(rerr[0]), .rsp_y(ry[0]),
        .alu_a(aa[0]), .alu_b(ab[0]), .alu_op(aop[0]), .alu_y(ay[0])
    );

    rv32i_alu_arbiter #(.FIXED_PRIO(1'b1), .XLEN(32)) u_fp (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .req0_valid(v0), .req0_ready(rdy0[1]), .req0_op(op0), .req0_a(a0), .req0_b(b0),
        .req1_valid(v1), .req1_ready(rdy1[1]), .req1_op(op1), .req1_a(a1), .req1_b(b1),
        .rsp0_valid(rv0[1]), .rsp1_valid(rv1[1]), .rsp_err(rerr[1]), .rsp_y(ry[1]),
        .alu_a(aa[1]), .alu_b(ab[1]), .alu_op(aop[1]), .alu_y(ay[1])
    );

    function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a ^ b;
            5:  return a | b;
            6:  return a & b;
            7:  return a << b[4:0];
            8:  return a >> b[4:0];
            9:  return $signed(a) >>> b[4:0];
            10: return (a == b) ? 32'd1 : 32'd0;
            11: return (a != b) ? 32'd1 : 32'd0;
            12: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            13: return (a >= b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // ALU stand-in: registered, driven by the one-hot lines, zero when none set.
    function automatic logic [31:0] alu_stub(input logic [13:0] oh, input logic [31:0] a, input logic [31:0] b);
        int k;
        k = -1;
        for (int i = 0; i < 14; i++) if (oh[i]) k = i;
        if (k < 0) return 32'd0;
        return alu_ref(k, a, b);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) ay[i] <= 32'd0;
            else     ay[i] <= alu_stub(aop[i], aa[i], ab[i]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit rv0_i, input int rop0, input logic [31:0] ra0, input logic [31:0] rb0,
                           input bit rv1_i, input int rop1, input logic [31:0] ra1, input logic [31:0] rb1);
        v0 = rv0_i; op0 = 4'(rop0); a0 = ra0; b0 = rb0;
        v1 = rv1_i; op1 = 4'(rop1); a1 = ra1; b1 = rb1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_last[d] = 1; m_busy[d] = 1'b0; m_id[d] = 0; m_err[d] = 1'b0; m_y[d] = 32'd0;
        end
    endtask

    // One cycle: check combinational issue and registered response, then advance the model.
    task automatic step();
        int          g   [2];
        int          sop [2];
        logic [31:0] sa  [2];
        logic [31:0] sb  [2];
        #1;
        for (int d = 0; d < 2; d++) begin
            g[d] = -1;
            if (!hold && !flush) begin
                if (v0 && v1)  g[d] = (d == 1) ? 0 : ((m_last[d] == 0) ? 1 : 0);
                else if (v0)   g[d] = 0;
                else if (v1)   g[d] = 1;
            end
            sop[d] = (g[d] == 1) ? int'(op1) : int'(op0);
            sa[d]  = (g[d] == 1) ? a1 : a0;
            sb[d]  = (g[d] == 1) ? b1 : b0;
            chk($sformatf("d%0d_req0_ready", d), {31'd0, rdy0[d]}, (g[d] == 0) ? 32'd1 : 32'd0);
            chk($sformatf("d%0d_req1_ready", d), {31'd0, rdy1[d]}, (g[d] == 1) ? 32'd1 : 32'd0);
            chk($sformatf("d%0d_alu_op", d), {18'd0, aop[d]},
                (g[d] >= 0 && sop[d] < 14) ? (32'd1 << sop[d]) : 32'd0);
            chk($sformatf("d%0d_alu_a", d), aa[d], sa[d]);
            chk($sformatf("d%0d_alu_b", d), ab[d], sb[d]);
            chk($sformatf("d%0d_rsp0_valid", d), {31'd0, rv0[d]}, (m_busy[d] && m_id[d] == 0) ? 32'd1 : 32'd0);
            chk($sformatf("d%0d_rsp1_valid", d), {31'd0, rv1[d]}, (m_busy[d] && m_id[d] == 1) ? 32'd1 : 32'd0);
            chk($sformatf("d%0d_rsp_err", d), {31'd0, rerr[d]}, (m_busy[d] && m_err[d]) ? 32'd1 : 32'd0);
            chk($sformatf("d%0d_rsp_y", d), ry[d], m_busy[d] ? m_y[d] : 32'd0);
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (g[d] >= 0) begin
                m_last[d] = g[d];
                m_busy[d] = 1'b1;
                m_id[d]   = g[d];
                m_err[d]  = (sop[d] >= 14);
                m_y[d]    = alu_ref(sop[d], sa[d], sb[d]);
            end else begin
                m_busy[d] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_d%0d_rsp0", tag, d), {31'd0, rv0[d]}, 32'd0);
            chk($sformatf("%s_d%0d_rsp1", tag, d), {31'd0, rv1[d]}, 32'd0);
            chk($sformatf("%s_d%0d_err", tag, d), {31'd0, rerr[d]}, 32'd0);
            chk($sformatf("%s_d%0d_y", tag, d), ry[d], 32'd0);
            chk($sformatf("%s_d%0d_rdy0", tag, d), {31'd0, rdy0[d]}, 32'd0);
            chk($sformatf("%s_d%0d_rdy1", tag, d), {31'd0, rdy1[d]}, 32'd0);
            chk($sformatf("%s_d%0d_aop", tag, d), {18'd0, aop[d]}, 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; flush = 1'b0;
        set_req(1'b1, 0, 32'd1, 32'd2, 1'b1, 0, 32'd3, 32'd4);
        #1;
        chk_quiet("in_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // ADD 5+7 on requester 0 only
        set_req(1'b1, 0, 32'd5, 32'd7, 1'b0, 0, 32'd0, 32'd0);
        step();
        chk("add_rsp_y", ry[0], 32'd12);
        chk("add_rsp0", {31'd0, rv0[0]}, 32'd1);

        // contention: SUB 10-3 vs SLT -1 < 1
        set_req(1'b1, 1, 32'd10, 32'd3, 1'b1, 2, 32'hFFFF_FFFF, 32'd1);
        repeat (4) step();

        // illegal op on requester 1
        set_req(1'b0, 0, 32'd0, 32'd0, 1'b1, 15, 32'd9, 32'd9);
        step();
        chk("illegal_rsp1", {31'd0, rv1[0]}, 32'd1);
        chk("illegal_err", {31'd0, rerr[0]}, 32'd1);
        chk("illegal_y", ry[0], 32'd0);

        // flush blocks acceptance, retry is accepted
        set_req(1'b1, 9, 32'h8000_0000, 32'd4, 1'b0, 0, 32'd0, 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("sra_rsp_y", ry[0], 32'hF800_0000);

        // hold for three cycles with both requesting, then hold with flush
        set_req(1'b1, 4, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 1'b1, 7, 32'd1, 32'd31);
        hold = 1'b1;
        repeat (3) step();
        flush = 1'b1;
        step();
        hold = 1'b0; flush = 1'b0;
        step();

        // randomized traffic
        repeat (300) begin
            set_req(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom, $urandom,
                    1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom, $urandom);
            hold  = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 9) == 0);
            step();
        end
        hold = 1'b0; flush = 1'b0;

        // reset while an op is in flight
        set_req(1'b1, 0, 32'd100, 32'd1, 1'b0, 0, 32'd0, 32'd0);
        step();
        rst = 1'b1;
        #1;
        chk_quiet("mid_reset");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        set_req(1'b1, 6, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1, 5, 32'h1, 32'h2);
        #1;
        chk("post_reset_rr_rdy0", {31'd0, rdy0[0]}, 32'd1);
        step();
        set_req(1'b0, 0, 32'd0, 32'd0, 1'b0, 0, 32'd0, 32'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
